// File: rtl/sysid_pkg.sv
// sysid_pkg: shared types for the boot-time system ID checker.
// State encodings, fail codes and sysid slave word addresses.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT,
    ST_PASS,
    ST_FAIL
  } state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT
  } rd_phase_e;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ID      = 2'd1;
  localparam logic [1:0] FAIL_TS      = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/avm_single_read.sv
// avm_single_read: one-word Avalon-MM read engine with timeout.
// Ports: launch/launch_addr in; avm_* bus; accept/rsp_valid/rsp_data/expired out.
module avm_single_read
  import sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        launch,
  input  logic        launch_addr,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        accept,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  rd_phase_e  phase_q;
  rd_phase_e  phase_d;
  logic [7:0] cnt_q;
  logic       active;

  always_comb begin
    active    = (phase_q != RD_IDLE);
    accept    = (phase_q == RD_REQ) && !avm_waitrequest;
    // responses outside the wait phase are stale and dropped
    rsp_valid = (phase_q == RD_WAIT) && avm_readdatavalid;
    rsp_data  = avm_readdata;
    // a response landing on the last cycle still counts
    expired   = active && !rsp_valid && (cnt_q == LAST);
    phase_d   = phase_q;
    if (launch)
      phase_d = RD_REQ;
    else if (rsp_valid || expired)
      phase_d = RD_IDLE;
    else if (accept)
      phase_d = RD_WAIT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= RD_IDLE;
      cnt_q       <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      avm_read <= (phase_d == RD_REQ);
      if (launch) begin
        cnt_q       <= '0;
        avm_address <= launch_addr;
      end else if (active) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid ID/timestamp words and reports pass/fail.
// Ports: start in; avm_* master; busy/done/pass/fail_code/id_value/ts_value out.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRIES);

  state_e      state_q;
  state_e      state_d;
  logic        auto_q;
  logic [7:0]  retry_q;
  logic        launch;
  logic        launch_addr;
  logic        begin_chk;
  logic        retry_clr;
  logic        retry_inc;
  logic [1:0]  code_d;
  logic        is_ts;
  logic        accept;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        expired;

  avm_single_read #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd (
    .clock            (clock),
    .reset            (reset),
    .launch           (launch),
    .launch_addr      (launch_addr),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .accept           (accept),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .expired          (expired)
  );

  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    launch_addr = SYSID_ADDR_ID;
    begin_chk   = 1'b0;
    retry_clr   = 1'b0;
    retry_inc   = 1'b0;
    code_d      = FAIL_NONE;
    is_ts       = (state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT);
    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start || auto_q) begin
          state_d   = ST_ID_REQ;
          launch    = 1'b1;
          begin_chk = 1'b1;
          retry_clr = 1'b1;
        end
      end
      ST_ID_REQ, ST_ID_WAIT, ST_TS_REQ, ST_TS_WAIT: begin
        if (rsp_valid) begin
          if (!is_ts) begin
            if (rsp_data != EXPECTED_ID) begin
              state_d = ST_FAIL;
              code_d  = FAIL_ID;
            end else begin
              state_d     = ST_TS_REQ;
              launch      = 1'b1;
              launch_addr = SYSID_ADDR_TS;
              retry_clr   = 1'b1;
            end
          end else if (CHECK_TS && rsp_data != EXPECTED_TS) begin
            state_d = ST_FAIL;
            code_d  = FAIL_TS;
          end else begin
            state_d = ST_PASS;
          end
        end else if (expired) begin
          if (retry_q < RETRY_LIM) begin
            retry_inc   = 1'b1;
            launch      = 1'b1;
            launch_addr = is_ts;
            state_d     = is_ts ? ST_TS_REQ : ST_ID_REQ;
          end else begin
            state_d = ST_FAIL;
            code_d  = FAIL_TIMEOUT;
          end
        end else if (accept) begin
          state_d = is_ts ? ST_TS_WAIT : ST_ID_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      auto_q    <= AUTO_START;
      retry_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FAIL_NONE;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= 1'b0;
      busy    <= state_d inside {ST_ID_REQ, ST_ID_WAIT,
                                 ST_TS_REQ, ST_TS_WAIT};
      done    <= (state_d inside {ST_PASS, ST_FAIL}) &&
                 !(state_q inside {ST_PASS, ST_FAIL});
      if (begin_chk) begin
        pass      <= 1'b0;
        fail_code <= FAIL_NONE;
      end
      if (state_d == ST_PASS && state_q != ST_PASS)
        pass <= 1'b1;
      if (code_d != FAIL_NONE)
        fail_code <= code_d;
      if (retry_clr)
        retry_q <= '0;
      else if (retry_inc)
        retry_q <= retry_q + 8'd1;
      if (rsp_valid && !is_ts)
        id_value <= rsp_data;
      if (rsp_valid && is_ts)
        ts_value <= rsp_data;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: randomized bench for sysid_checker.
// Two DUTs (CHECK_TS=1 and 0) share one behavioural sysid slave.
module tb_sysid_checker;
  import sysid_pkg::*;

  localparam logic [31:0] EXP_ID = 32'hCAFE_0123;
  localparam logic [31:0] EXP_TS = 32'h6512_3456;
  localparam int          TMO    = 15;
  localparam int          RETR   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = '0;

  logic        a_addr, a_read, a_busy, a_done, a_pass;
  logic [1:0]  a_code;
  logic [31:0] a_id, a_ts;
  logic        b_addr, b_read, b_busy, b_done, b_pass;
  logic [1:0]  b_code;
  logic [31:0] b_id, b_ts;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RETR), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(a_addr), .avm_read(a_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail_code(a_code),
    .id_value(a_id), .ts_value(a_ts)
  );

  sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RETR), .AUTO_START(1'b1)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(b_addr), .avm_read(b_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail_code(b_code),
    .id_value(b_id), .ts_value(b_ts)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [1:0] model_code(input bit respond,
      input logic [31:0] id, input logic [31:0] ts, input bit check_ts);
    if (!respond) return FAIL_TIMEOUT;
    if (id != EXP_ID) return FAIL_ID;
    if (check_ts && ts != EXP_TS) return FAIL_TS;
    return FAIL_NONE;
  endfunction

  // cycle of the done pulse counted from the start cycle (cycle 0):
  // each read costs 1 request cycle + w stalls + d response latency
  function automatic int model_done(input int w, input int d,
                                    input logic [1:0] code);
    if (code == FAIL_ID) return 2 + w + d;
    return 3 + 2 * w + 2 * d;
  endfunction

  // caller sits #1 after a posedge; this cycle is cycle 0
  task automatic run_check(input bit do_start, input logic [31:0] id_d,
      input logic [31:0] ts_d, input int w, input int d,
      input bit respond, input bit stale, input string tag);
    int cyc, stall, pend, acc0, acc1, dones_a, dones_b, done_cyc;
    int addr_bad, tail;
    logic pend_addr, hold_addr;
    logic [1:0] exp_a, exp_b;
    cyc = 0; stall = 0; pend = 0; acc0 = 0; acc1 = 0;
    dones_a = 0; dones_b = 0; done_cyc = -1; addr_bad = 0; tail = 0;
    pend_addr = 1'b0; hold_addr = 1'b0;
    start = do_start;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = stale;
    avm_readdata = 32'hDEAD_BEEF;
    while (tail < 3 && cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
      start = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_waitrequest = 1'b0;
      if (a_done) begin
        dones_a++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (b_done) dones_b++;
      if (done_cyc >= 0) tail++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = pend_addr ? ts_d : id_d;
        end
      end else if (stale && acc0 == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hDEAD_BEEF;
      end
      if (a_read) begin
        if (stall == 0) hold_addr = a_addr;
        else if (a_addr !== hold_addr) addr_bad++;
        if (stall < w) begin
          avm_waitrequest = 1'b1;
          stall++;
        end else begin
          stall = 0;
          if (a_addr) acc1++;
          else acc0++;
          if (respond) begin
            pend = d;
            pend_addr = a_addr;
          end
        end
      end
    end
    if (done_cyc < 0) chk({tag, "_done_seen"}, 32'd0, 32'd1);
    exp_a = model_code(respond, id_d, ts_d, 1'b1);
    exp_b = model_code(respond, id_d, ts_d, 1'b0);
    chk({tag, "_code_a"}, 32'(a_code), 32'(exp_a));
    chk({tag, "_code_b"}, 32'(b_code), 32'(exp_b));
    chk({tag, "_pass_a"}, 32'(a_pass), 32'(exp_a == FAIL_NONE));
    chk({tag, "_pass_b"}, 32'(b_pass), 32'(exp_b == FAIL_NONE));
    chk({tag, "_done_a"}, dones_a, 32'd1);
    chk({tag, "_done_b"}, dones_b, 32'd1);
    chk({tag, "_addr_stable"}, addr_bad, 32'd0);
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_ts_reads"}, acc1,
        32'((respond && id_d == EXP_ID) ? 1 : 0));
    if (respond) begin
      chk({tag, "_done_cyc"}, done_cyc, model_done(w, d, exp_a));
      chk({tag, "_id_value"}, a_id, id_d);
    end else begin
      chk({tag, "_id_reads"}, acc0, 32'(RETR + 1));
    end
    if (respond && id_d == EXP_ID) begin
      chk({tag, "_ts_value_a"}, a_ts, ts_d);
      chk({tag, "_ts_value_b"}, b_ts, ts_d);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_read"}, 32'(a_read), 32'd0);
    chk({tag, "_addr"}, 32'(a_addr), 32'd0);
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_done"}, 32'(a_done), 32'd0);
    chk({tag, "_pass"}, 32'(a_pass), 32'd0);
    chk({tag, "_code"}, 32'(a_code), 32'd0);
    chk({tag, "_id"}, a_id, 32'd0);
    chk({tag, "_ts"}, a_ts, 32'd0);
    chk({tag, "_pass_b"}, 32'(b_pass), 32'd0);
  endtask

  initial begin
    logic [31:0] id_d, ts_d;
    int w, d;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    run_check(1'b0, EXP_ID, EXP_TS, 0, 1, 1'b1, 1'b0, "auto");

    id_d = EXP_ID ^ (32'h1 << $urandom_range(31, 0));
    run_check(1'b1, id_d, EXP_TS, 0, 1, 1'b1, 1'b0, "id_bit");

    run_check(1'b1, EXP_ID, EXP_TS, 10, 3, 1'b1, 1'b0, "stall");

    ts_d = EXP_TS ^ 32'h0000_0100;
    run_check(1'b1, EXP_ID, ts_d, 0, 1, 1'b1, 1'b0, "ts_bad");

    for (int i = 0; i < 10; i++) begin
      w = int'($urandom_range(4, 0));
      d = int'($urandom_range(4, 1));
      id_d = EXP_ID;
      ts_d = EXP_TS;
      if ($urandom_range(2, 0) == 0)
        id_d = EXP_ID ^ (32'h1 << $urandom_range(31, 0));
      if ($urandom_range(2, 0) == 0)
        ts_d = $urandom;
      run_check(1'b1, id_d, ts_d, w, d, 1'b1, 1'b0, "rand");
    end

    run_check(1'b1, EXP_ID, EXP_TS, 0, 1, 1'b0, 1'b0, "timeout");

    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    avm_waitrequest = 1'b0;
    @(posedge clock); #1;
    chk("mid_wait_busy", 32'(a_busy), 32'd1);
    chk("mid_wait_read", 32'(a_read), 32'd0);
    reset = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata = EXP_ID;
    @(posedge clock); #1;
    chk_zero("mid_reset");
    reset = 1'b0;
    run_check(1'b0, EXP_ID, EXP_TS, 3, 1, 1'b1, 1'b1, "stale");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
